// File: rtl/pipe_pkg.sv
//------------------------------------------------------------------------------
// Module      : pipe_pkg
// Description : Shared stage-bundle types and default sizes for pipe_stage_buf.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package pipe_pkg;

    localparam int PIPE_DEPTH_DEFAULT     = 2;
    localparam int PIPE_CNT_WIDTH_DEFAULT = 32;

    // Instantiators derive DATA_WIDTH as $bits(<bundle>_t).
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } pipe_i2i_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [4:0]  rd;
        logic [31:0] src1;
        logic [31:0] src2;
        logic [31:0] imm;
        logic [7:0]  op;
    } pipe_i2e_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [4:0]  rd;
        logic [31:0] result;
        logic [31:0] store_data;
        logic        is_load;
        logic        is_store;
        logic [2:0]  mem_size;
    } pipe_e2l_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [4:0]  rd;
        logic [31:0] wb_data;
        logic        wb_en;
    } pipe_l2w_t;

endpackage

`default_nettype wire

// File: rtl/pipe_sat_cnt.sv
//------------------------------------------------------------------------------
// Module      : pipe_sat_cnt
// Description : Saturating up-counter, holds at all-ones, cleared by reset only.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module pipe_sat_cnt #(
    parameter int CNT_WIDTH = 32
) (
    input  logic                 i_sys_clk,
    input  logic                 i_sys_rst_n,
    input  logic                 i_inc,
    output logic [CNT_WIDTH-1:0] o_cnt
);

    logic [CNT_WIDTH-1:0] r_cnt;

    always_ff @(posedge i_sys_clk or negedge i_sys_rst_n) begin
        if (!i_sys_rst_n) begin
            r_cnt <= '0;
        end else if (i_inc && (r_cnt != '1)) begin
            r_cnt <= r_cnt + CNT_WIDTH'(1);
        end
    end

    assign o_cnt = r_cnt;

endmodule

`default_nettype wire

// File: rtl/pipe_stage_buf.sv
//------------------------------------------------------------------------------
// Module      : pipe_stage_buf
// Description : DEPTH-entry valid/ready elastic buffer between pipeline stages,
//               with flush; PIPE_BUF_PERF_EN adds stall/bubble counters.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module pipe_stage_buf
    import pipe_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = PIPE_DEPTH_DEFAULT,
    parameter int CNT_WIDTH  = PIPE_CNT_WIDTH_DEFAULT
) (
    input  logic                       i_sys_clk,
    input  logic                       i_sys_rst_n,
    input  logic                       i_flush,
    input  logic                       i_prev_valid,
    output logic                       o_buf_ready,
    input  logic [DATA_WIDTH-1:0]      i_prev_data,
    output logic                       o_buf_valid,
    input  logic                       i_next_ready,
    output logic [DATA_WIDTH-1:0]      o_buf_data,
    output logic [$clog2(DEPTH+1)-1:0] o_buf_count
`ifdef PIPE_BUF_PERF_EN
    ,
    output logic [CNT_WIDTH-1:0]       o_perf_stall_cnt,
    output logic [CNT_WIDTH-1:0]       o_perf_bubble_cnt
`endif
);

    localparam int C_PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int C_CNT_W = $clog2(DEPTH + 1);
    localparam logic [C_CNT_W-1:0] C_FULL = C_CNT_W'(DEPTH);

    generate
        if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
            $fatal(1, "pipe_stage_buf: DEPTH must be a power of two >= 2");
        end
        if (CNT_WIDTH < 1) begin : g_bad_cnt_width
            $fatal(1, "pipe_stage_buf: CNT_WIDTH must be >= 1");
        end
    endgenerate

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [C_PTR_W-1:0]    r_wr_ptr;
    logic [C_PTR_W-1:0]    r_rd_ptr;
    logic [C_CNT_W-1:0]    r_count;
    logic                  w_push;
    logic                  w_pop;

    // Ready comes from occupancy alone, so no downstream-to-upstream comb path.
    assign o_buf_ready = (r_count < C_FULL);
    assign o_buf_valid = (r_count != '0);
    assign o_buf_data  = r_mem[r_rd_ptr];
    assign o_buf_count = r_count;

    assign w_push = i_prev_valid && o_buf_ready;
    assign w_pop  = o_buf_valid && i_next_ready;

    always_ff @(posedge i_sys_clk or negedge i_sys_rst_n) begin
        if (!i_sys_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + C_PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + C_PTR_W'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + C_CNT_W'(1);
            end else if (w_pop && !w_push) begin
                r_count <= r_count - C_CNT_W'(1);
            end
        end
    end

    // Payload storage is intentionally left out of reset and flush.
    always_ff @(posedge i_sys_clk) begin
        if (w_push && !i_flush) begin
            r_mem[r_wr_ptr] <= i_prev_data;
        end
    end

`ifdef PIPE_BUF_PERF_EN
    logic w_stall_inc;
    logic w_bubble_inc;

    assign w_stall_inc  = o_buf_valid && !i_next_ready && !i_flush;
    assign w_bubble_inc = !o_buf_valid && i_next_ready && !i_flush;

    pipe_sat_cnt #(
        .CNT_WIDTH (CNT_WIDTH)
    ) u_stall_cnt (
        .i_sys_clk   (i_sys_clk),
        .i_sys_rst_n (i_sys_rst_n),
        .i_inc       (w_stall_inc),
        .o_cnt       (o_perf_stall_cnt)
    );

    pipe_sat_cnt #(
        .CNT_WIDTH (CNT_WIDTH)
    ) u_bubble_cnt (
        .i_sys_clk   (i_sys_clk),
        .i_sys_rst_n (i_sys_rst_n),
        .i_inc       (w_bubble_inc),
        .o_cnt       (o_perf_bubble_cnt)
    );
`endif

endmodule

`default_nettype wire

// File: tb/tb_pipe_stage_buf.sv
//------------------------------------------------------------------------------
// Module      : tb_pipe_stage_buf
// Description : Directed self-checking bench for pipe_stage_buf (DEPTH=2).
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_pipe_stage_buf;

    localparam int DW = 32;
    localparam int DP = 2;
    localparam int CW = 4;

    logic          clk;
    logic          rst_n;
    logic          flush;
    logic          prev_valid;
    logic          buf_ready;
    logic [DW-1:0] prev_data;
    logic          buf_valid;
    logic          next_ready;
    logic [DW-1:0] buf_data;
    logic [1:0]    buf_count;
`ifdef PIPE_BUF_PERF_EN
    logic [CW-1:0] stall_cnt;
    logic [CW-1:0] bubble_cnt;
`endif

    int n_cmp  = 0;
    int n_fail = 0;

    pipe_stage_buf #(
        .DATA_WIDTH (DW),
        .DEPTH      (DP),
        .CNT_WIDTH  (CW)
    ) dut (
        .i_sys_clk    (clk),
        .i_sys_rst_n  (rst_n),
        .i_flush      (flush),
        .i_prev_valid (prev_valid),
        .o_buf_ready  (buf_ready),
        .i_prev_data  (prev_data),
        .o_buf_valid  (buf_valid),
        .i_next_ready (next_ready),
        .o_buf_data   (buf_data),
        .o_buf_count  (buf_count)
`ifdef PIPE_BUF_PERF_EN
        ,
        .o_perf_stall_cnt  (stall_cnt),
        .o_perf_bubble_cnt (bubble_cnt)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        #2;
        n_cmp++; if (buf_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got=%b exp=0", buf_valid); end
        n_cmp++; if (buf_count !== 2'd0) begin n_fail++; $display("FAIL reset_count got=%0d exp=0", buf_count); end
        n_cmp++; if (buf_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready got=%b exp=1", buf_ready); end
`ifdef PIPE_BUF_PERF_EN
        n_cmp++; if (stall_cnt !== 4'h0) begin n_fail++; $display("FAIL reset_stall got=%h exp=0", stall_cnt); end
        n_cmp++; if (bubble_cnt !== 4'h0) begin n_fail++; $display("FAIL reset_bubble got=%h exp=0", bubble_cnt); end
`endif
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_single;
        prev_valid = 1'b1; prev_data = 32'h11; next_ready = 1'b1;
        tick();
        prev_valid = 1'b0;
        n_cmp++; if (buf_valid !== 1'b1) begin n_fail++; $display("FAIL single_valid got=%b exp=1", buf_valid); end
        n_cmp++; if (buf_data !== 32'h11) begin n_fail++; $display("FAIL single_data got=%h exp=11", buf_data); end
        n_cmp++; if (buf_count !== 2'd1) begin n_fail++; $display("FAIL single_count got=%0d exp=1", buf_count); end
        tick();
        n_cmp++; if (buf_count !== 2'd0) begin n_fail++; $display("FAIL single_drain_count got=%0d exp=0", buf_count); end
        n_cmp++; if (buf_valid !== 1'b0) begin n_fail++; $display("FAIL single_drain_valid got=%b exp=0", buf_valid); end
    endtask

    task automatic test_back_to_back;
        next_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            prev_valid = 1'b1; prev_data = DW'(i);
            tick();
            n_cmp++; if (buf_valid !== 1'b1 || buf_data !== DW'(i)) begin n_fail++; $display("FAIL b2b_out[%0d] got v=%b d=%h exp v=1 d=%h", i, buf_valid, buf_data, i); end
            n_cmp++; if (buf_ready !== 1'b1 || buf_count !== 2'd1) begin n_fail++; $display("FAIL b2b_ready[%0d] got r=%b c=%0d exp r=1 c=1", i, buf_ready, buf_count); end
        end
        prev_valid = 1'b0;
        tick();
        n_cmp++; if (buf_count !== 2'd0) begin n_fail++; $display("FAIL b2b_drain got=%0d exp=0", buf_count); end
    endtask

    task automatic test_backpressure;
        next_ready = 1'b0;
        prev_valid = 1'b1; prev_data = 32'hA;
        tick();
        n_cmp++; if (buf_count !== 2'd1 || buf_ready !== 1'b1) begin n_fail++; $display("FAIL bp_first got c=%0d r=%b exp c=1 r=1", buf_count, buf_ready); end
        prev_data = 32'hB;
        tick();
        n_cmp++; if (buf_count !== 2'd2 || buf_ready !== 1'b0) begin n_fail++; $display("FAIL bp_full got c=%0d r=%b exp c=2 r=0", buf_count, buf_ready); end
        prev_data = 32'hC;
        tick();
        n_cmp++; if (buf_count !== 2'd2 || buf_data !== 32'hA) begin n_fail++; $display("FAIL bp_hold got c=%0d d=%h exp c=2 d=a", buf_count, buf_data); end
        next_ready = 1'b1;
        tick();
        n_cmp++; if (buf_count !== 2'd1 || buf_data !== 32'hB) begin n_fail++; $display("FAIL bp_pop_a got c=%0d d=%h exp c=1 d=b", buf_count, buf_data); end
        tick();
        prev_valid = 1'b0;
        n_cmp++; if (buf_count !== 2'd1 || buf_data !== 32'hC) begin n_fail++; $display("FAIL bp_pop_b got c=%0d d=%h exp c=1 d=c", buf_count, buf_data); end
        tick();
        n_cmp++; if (buf_valid !== 1'b0) begin n_fail++; $display("FAIL bp_drain got v=%b exp v=0", buf_valid); end
    endtask

    task automatic test_flush;
        next_ready = 1'b0;
        prev_valid = 1'b1; prev_data = 32'h21;
        tick();
        prev_data = 32'h22;
        tick();
        n_cmp++; if (buf_count !== 2'd2) begin n_fail++; $display("FAIL flush_fill got=%0d exp=2", buf_count); end
        flush = 1'b1; prev_data = 32'hD; next_ready = 1'b1;
        tick();
        flush = 1'b0; prev_valid = 1'b0;
        n_cmp++; if (buf_valid !== 1'b0 || buf_count !== 2'd0 || buf_ready !== 1'b1) begin n_fail++; $display("FAIL flush_state got v=%b c=%0d r=%b exp v=0 c=0 r=1", buf_valid, buf_count, buf_ready); end
        tick();
        n_cmp++; if (buf_valid !== 1'b0) begin n_fail++; $display("FAIL flush_no_d got v=%b d=%h exp v=0", buf_valid, buf_data); end
        prev_valid = 1'b1; prev_data = 32'h31; next_ready = 1'b0;
        tick();
        prev_valid = 1'b0;
        n_cmp++; if (buf_valid !== 1'b1 || buf_data !== 32'h31) begin n_fail++; $display("FAIL flush_repush got v=%b d=%h exp v=1 d=31", buf_valid, buf_data); end
        next_ready = 1'b1;
        tick();
        n_cmp++; if (buf_count !== 2'd0) begin n_fail++; $display("FAIL flush_drain got=%0d exp=0", buf_count); end
    endtask

    task automatic test_async_reset;
        next_ready = 1'b0;
        prev_valid = 1'b1; prev_data = 32'h41;
        tick();
        prev_valid = 1'b0;
        n_cmp++; if (buf_count !== 2'd1) begin n_fail++; $display("FAIL arst_pre got=%0d exp=1", buf_count); end
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++; if (buf_valid !== 1'b0 || buf_count !== 2'd0) begin n_fail++; $display("FAIL arst_now got v=%b c=%0d exp v=0 c=0", buf_valid, buf_count); end
        prev_valid = 1'b1; prev_data = 32'h42;
        tick();
        n_cmp++; if (buf_count !== 2'd0) begin n_fail++; $display("FAIL arst_push_ignored got=%0d exp=0", buf_count); end
        prev_valid = 1'b0;
        rst_n = 1'b1;
        tick();
        n_cmp++; if (buf_count !== 2'd0 || buf_ready !== 1'b1) begin n_fail++; $display("FAIL arst_release got c=%0d r=%b exp c=0 r=1", buf_count, buf_ready); end
    endtask

`ifdef PIPE_BUF_PERF_EN
    task automatic test_perf;
        next_ready = 1'b0;
        n_cmp++; if (stall_cnt !== 4'h0 || bubble_cnt !== 4'h0) begin n_fail++; $display("FAIL perf_start got s=%h b=%h exp s=0 b=0", stall_cnt, bubble_cnt); end
        prev_valid = 1'b1; prev_data = 32'h51;
        tick();
        prev_valid = 1'b0;
        repeat (3) tick();
        n_cmp++; if (stall_cnt !== 4'h3) begin n_fail++; $display("FAIL perf_stall3 got=%h exp=3", stall_cnt); end
        repeat (17) tick();
        n_cmp++; if (stall_cnt !== 4'hF) begin n_fail++; $display("FAIL perf_stall_sat got=%h exp=f", stall_cnt); end
        n_cmp++; if (bubble_cnt !== 4'h0) begin n_fail++; $display("FAIL perf_bubble_zero got=%h exp=0", bubble_cnt); end
        flush = 1'b1; next_ready = 1'b1;
        tick();
        flush = 1'b0;
        n_cmp++; if (stall_cnt !== 4'hF || bubble_cnt !== 4'h0) begin n_fail++; $display("FAIL perf_flush got s=%h b=%h exp s=f b=0", stall_cnt, bubble_cnt); end
        repeat (2) tick();
        n_cmp++; if (bubble_cnt !== 4'h2) begin n_fail++; $display("FAIL perf_bubble got=%h exp=2", bubble_cnt); end
    endtask
`endif

    initial begin
        rst_n = 1'b0; flush = 1'b0; prev_valid = 1'b0; prev_data = '0; next_ready = 1'b0;
        test_reset();
        test_single();
        test_back_to_back();
        test_backpressure();
        test_flush();
        test_async_reset();
`ifdef PIPE_BUF_PERF_EN
        test_perf();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/pipe_stage_buf.md
# pipe_stage_buf

Parametrised valid/ready pipeline buffer inserted between CPU stages (IFU→IDU, IDU→EXU, EXU→LSU, LSU→WBU). It replaces the single-register stage latches with a DEPTH-entry elastic buffer carrying an opaque packed payload. It sustains full throughput with no combinational ready path from downstream to upstream. It also supports a synchronous flush for jump redirects, and optional stall/bubble performance counters.

## Interface
- DATA_WIDTH, 32, payload width in bits (stage bundle packed by the instantiator)
- DEPTH, 2, number of entries; power of two, ≥2 (elaboration-time check, fatal otherwise)
- CNT_WIDTH, 32, performance counter width
- i_sys_clk  in  1  clock, all state on rising edge
- i_sys_rst_n  in  1  reset, asynchronous, active-low
- i_flush  in  1  discard all contents (jump redirect)
- i_prev_valid  in  1  upstream presents payload
- o_buf_ready  out  1  buffer accepts payload this cycle
- i_prev_data  in  DATA_WIDTH  upstream payload
- o_buf_valid  out  1  head entry valid for downstream
- i_next_ready  in  1  downstream accepts head
- o_buf_data  out  DATA_WIDTH  head entry payload
- o_buf_count  out  $clog2(DEPTH+1)  occupied entries
- o_perf_stall_cnt  out  CNT_WIDTH  cycles valid && !ready downstream (PIPE_BUF_PERF_EN only)
- o_perf_bubble_cnt  out  CNT_WIDTH  cycles !valid && downstream ready (PIPE_BUF_PERF_EN only)

## Operation
- Push = i_prev_valid && o_buf_ready; pop = o_buf_valid && i_next_ready.
- Storage: DEPTH-entry register array, write pointer and read pointer of $clog2(DEPTH) bits; both wrap naturally from DEPTH-1 to 0.
- o_buf_ready = (count < DEPTH), from registered state only; it never depends on i_next_ready.
- o_buf_valid = (count != 0); o_buf_data = mem[rd_ptr], driven from registers.
- Occupancy states: EMPTY (count 0), PARTIAL (0<count<DEPTH), FULL (count DEPTH).
  - EMPTY: push → PARTIAL.
  - PARTIAL: push only → count+1 (FULL if it reaches DEPTH); pop only → count−1; both → count unchanged, both pointers advance.
  - FULL: push impossible (ready low); pop → PARTIAL.
- Pop from EMPTY is impossible, because valid is low.
- Flush has priority over everything. On the edge where i_flush=1: count←0 and wr_ptr←rd_ptr←0. Any simultaneous push or pop is discarded and counted as nothing.
- Entry contents are not cleared on flush or reset. o_buf_data is don't-care while o_buf_valid=0, and the bench must not check it then.
- Push attempts while i_sys_rst_n=0 are ignored.

## Timing
- Reset values: o_buf_valid=0, o_buf_count=0, o_buf_ready=1, pointers 0, perf counters 0. o_buf_data is X/don't-care.
- Latency: a payload pushed at edge N is visible on o_buf_valid/o_buf_data after edge N, i.e. one cycle.
- Throughput: 1 payload/cycle sustained for DEPTH≥2 with i_next_ready held high.
- After i_next_ready deasserts, up to DEPTH payloads are absorbed before o_buf_ready falls.
- Flush at edge N: o_buf_valid=0 and o_buf_ready=1 in cycle N+1. The first post-flush push can occur in cycle N+1.
- Reset mid-operation: all state returns to reset values immediately (asynchronous); release is on the next clock edge.

## Configuration
- PIPE_BUF_PERF_EN defined: adds o_perf_stall_cnt and o_perf_bubble_cnt.
  - Each increments by 1 per qualifying cycle and saturates at all-ones.
  - Both are cleared by reset only, never by flush.
  - Neither counts during a cycle with i_flush=1.
- PIPE_BUF_PERF_EN undefined: both ports and their logic are absent.

## Structure
- Shared package pipe_pkg:
  - packed struct typedefs for each stage bundle (i2i, i2e, e2l, l2w payloads), so instantiators derive DATA_WIDTH as $bits(type);
  - default DEPTH and CNT_WIDTH constants.
- One sub-module: pipe_sat_cnt, a saturating counter with CNT_WIDTH parameter and an increment-enable input. It is instantiated twice under PIPE_BUF_PERF_EN.

## Test plan
- Reset, then push A=0x11 at cycle 1 with i_next_ready=1 → o_buf_valid=1, o_buf_data=0x11 at cycle 2; count returns to 0 at cycle 3.
- Stream 0x1..0x8 back-to-back with i_next_ready=1, DEPTH=2 → 8 consecutive output cycles in order; o_buf_ready stays 1.
- i_next_ready=0 while pushing 0xA,0xB,0xC → 0xA and 0xB accepted, count=2, ready=0, 0xC held upstream. Then assert i_next_ready → outputs 0xA,0xB,0xC in order; pointers wrap with no loss.
- Buffer holding 2 entries, i_flush=1 with simultaneous push 0xD and pop → next cycle valid=0, count=0, ready=1; 0xD never appears.
- Deassert i_sys_rst_n mid-stream with count=1 → valid=0 and count=0 immediately, without a clock edge.
- PIPE_BUF_PERF_EN with CNT_WIDTH=4: hold valid with i_next_ready=0 for 20 cycles → o_perf_stall_cnt saturates at 0xF; a flush leaves it at 0xF.
